dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters.
  - Port A: pipeline MEM stage; single access per cycle; highest priority.
  - Port B: loader/debug DMA; word bursts of 1..16 beats.
- Sits between the MEM stage, the DMA engine and the data memory.
- Drives the data memory's we/memlen/addr/wdata and returns its combinational rdata.
- Stalls the pipeline while B owns the port; bounds B's wait with a starvation counter.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline MEM stage (A) versus DMA bursts (B).
// A wins in IDLE unless B has waited MAX_WAIT cycles; B owns the port in BURST.
module dmem_arbiter #(
    parameter int MAX_WAIT    = 4,
    parameter int BEAT_STRIDE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_memlen,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_stall,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_memlen,
    input  logic [31:0] b_addr,
    input  logic [3:0]  b_len,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_ack,
    output logic        b_done,
    output logic        mem_we,
    output logic [2:0]  mem_memlen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [3:0]    beat_cnt;
    logic [3:0]    len_q;
    logic          we_q;
    logic [2:0]    memlen_q;
    logic [31:0]   burst_addr;
    logic [31:0]   beat_addr;
    logic          starved;
    logic          grant;
    logic          last_beat;

    assign starved   = (starve_cnt == SW'(MAX_WAIT));
    assign grant     = (state == IDLE) && b_req && (!a_req || starved);
    assign last_beat = (state == BURST) && (beat_cnt == len_q);
    assign beat_addr = burst_addr + (32'(BEAT_STRIDE) * {28'd0, beat_cnt});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = BURST;
            BURST:   if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst parameters are captured at grant so B may change them freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            beat_cnt   <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            memlen_q   <= '0;
            burst_addr <= '0;
        end else if (grant) begin
            starve_cnt <= '0;
            beat_cnt   <= '0;
            len_q      <= b_len;
            we_q       <= b_we;
            memlen_q   <= b_memlen;
            burst_addr <= b_addr;
        end else if (state == BURST) begin
            beat_cnt <= beat_cnt + 4'd1;
        end else if (!b_req) begin
            starve_cnt <= '0;
        end else if (a_req && !starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_memlen = a_memlen;
        mem_addr   = a_addr;
        mem_wdata  = a_wdata;
        a_rdata    = mem_rdata;
        b_rdata    = mem_rdata;
        a_stall    = 1'b0;
        b_ack      = 1'b0;
        b_done     = 1'b0;
        unique case (state)
            IDLE: begin
                mem_we = a_req && a_we && !rst;
            end
            BURST: begin
                mem_we     = we_q && !rst;
                mem_memlen = memlen_q;
                mem_addr   = beat_addr;
                mem_wdata  = b_wdata;
                a_stall    = a_req && !rst;
                b_ack      = !rst;
                b_done     = last_beat && !rst;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table followed by random traffic
// checked against a queue-based model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int MAX_WAIT    = 4;
    localparam int BEAT_STRIDE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we;
    logic [2:0]  a_memlen;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_stall;
    logic        b_req, b_we;
    logic [2:0]  b_memlen;
    logic [31:0] b_addr;
    logic [3:0]  b_len;
    logic [31:0] b_wdata, b_rdata;
    logic        b_ack, b_done;
    logic        mem_we;
    logic [2:0]  mem_memlen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BEAT_STRIDE(BEAT_STRIDE)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_memlen(a_memlen), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_stall(a_stall),
        .b_req(b_req), .b_we(b_we), .b_memlen(b_memlen), .b_addr(b_addr),
        .b_len(b_len), .b_wdata(b_wdata), .b_rdata(b_rdata),
        .b_ack(b_ack), .b_done(b_done),
        .mem_we(mem_we), .mem_memlen(mem_memlen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ar, aw;
        logic [31:0] aa, ad;
        logic        br, bw;
        logic [31:0] ba;
        logic [3:0]  bl;
        logic [31:0] bd;
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_stall, e_ack, e_done;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a pending burst is just the list of its beat addresses.
    bit          m_busy = 1'b0;
    int          m_loss = 0;
    logic [31:0] m_q[$];
    logic        m_we;
    logic [2:0]  m_ml;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic ar, input logic aw,
                       input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [31:0] ba,
                       input logic [3:0] bl, input logic [31:0] bd,
                       input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                       input logic es, input logic ek, input logic en);
        vec_t v;
        v.rst = r; v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bl = bl; v.bd = bd;
        v.e_we = ew; v.e_addr = ea; v.e_wdata = ed;
        v.e_stall = es; v.e_ack = ek; v.e_done = en;
        vecs.push_back(v);
    endtask

    task automatic model_update();
        if (rst) begin
            m_busy = 1'b0;
            m_q.delete();
            m_loss = 0;
        end else if (m_busy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_busy = 1'b0;
        end else if (b_req && (!a_req || m_loss >= MAX_WAIT)) begin
            for (int i = 0; i <= int'(b_len); i++)
                m_q.push_back(b_addr + 32'(i * BEAT_STRIDE));
            m_we   = b_we;
            m_ml   = b_memlen;
            m_busy = 1'b1;
            m_loss = 0;
        end else if (!b_req) begin
            m_loss = 0;
        end else if (m_loss < MAX_WAIT) begin
            m_loss++;
        end
    endtask

    task automatic model_check();
        if (rst) begin
            chk("m_rst_mem_we", 32'(mem_we), 32'd0);
            chk("m_rst_b_done", 32'(b_done), 32'd0);
        end else if (!m_busy) begin
            chk("m_idle_mem_we", 32'(mem_we), 32'(a_req & a_we));
            chk("m_idle_addr", mem_addr, a_addr);
            chk("m_idle_memlen", 32'(mem_memlen), 32'(a_memlen));
            chk("m_idle_wdata", mem_wdata, a_wdata);
            chk("m_idle_rdata", a_rdata, mem_rdata);
            chk("m_idle_stall", 32'(a_stall), 32'd0);
            chk("m_idle_ack", 32'(b_ack), 32'd0);
            chk("m_idle_done", 32'(b_done), 32'd0);
        end else begin
            chk("m_burst_mem_we", 32'(mem_we), 32'(m_we));
            chk("m_burst_addr", mem_addr, m_q[0]);
            chk("m_burst_memlen", 32'(mem_memlen), 32'(m_ml));
            chk("m_burst_wdata", mem_wdata, b_wdata);
            chk("m_burst_rdata", b_rdata, mem_rdata);
            chk("m_burst_stall", 32'(a_stall), 32'(a_req));
            chk("m_burst_ack", 32'(b_ack), 32'd1);
            chk("m_burst_done", 32'(b_done), 32'(m_q.size() == 1));
        end
    endtask

    initial begin
        rst = 1'b1; a_req = 0; a_we = 0; a_memlen = 3'd2; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_memlen = 3'd5; b_addr = 0; b_len = 0; b_wdata = 0;
        mem_rdata = 0;

        // reset with both requesters active: no write may escape
        add(1,1,1,32'h10,32'hDEADBEEF,1,1,32'h40,3,0, 0,0,0,0,0,0);
        add(1,1,1,32'h10,32'hDEADBEEF,1,1,32'h40,3,0, 0,0,0,0,0,0);
        // A only
        for (int i = 0; i < 3; i++)
            add(0,1,1,32'h10,32'hDEADBEEF,0,0,0,0,0, 1,32'h10,32'hDEADBEEF,0,0,0);
        // B-only read burst; b_addr/b_len change and b_req drops mid-burst
        add(0,0,0,0,0,1,0,32'h40,3,0, 0,0,0,0,0,0);
        add(0,0,0,0,0,1,0,32'h40,3,0, 0,32'h40,0,0,1,0);
        add(0,0,0,0,0,1,0,32'h999,0,0, 0,32'h44,0,0,1,0);
        add(0,0,0,0,0,0,0,32'h999,0,0, 0,32'h48,0,0,1,0);
        add(0,0,0,0,0,0,0,0,0,0, 0,32'h4C,0,0,1,1);
        add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
        // starvation: A wins cycles 0-4, B forced in on cycle 5
        for (int i = 0; i < 5; i++)
            add(0,1,1,32'h20,32'h5A5A5A5A,1,0,32'h80,0,0, 1,32'h20,32'h5A5A5A5A,0,0,0);
        add(0,1,1,32'h20,32'h5A5A5A5A,1,0,32'h80,0,0, 0,32'h80,0,1,1,1);
        add(0,1,1,32'h20,32'h5A5A5A5A,0,0,0,0,0, 1,32'h20,32'h5A5A5A5A,0,0,0);
        // write burst wrapping past the top of the address space
        add(0,0,0,32'h20,0,1,1,32'hFFFFFFFC,1,32'h11111111, 0,32'h20,0,0,0,0);
        add(0,0,0,32'h20,0,1,1,32'hFFFFFFFC,1,32'h11111111, 1,32'hFFFFFFFC,32'h11111111,0,1,0);
        add(0,0,0,32'h20,0,1,1,32'hFFFFFFFC,1,32'h22222222, 1,32'h0,32'h22222222,0,1,1);
        add(0,0,0,32'h20,0,0,0,0,0,0, 0,32'h20,0,0,0,0);
        // re-arbitration: b_req stays high after b_done, A gets the next slot
        add(0,0,0,32'h30,0,1,0,32'h100,0,0, 0,32'h30,0,0,0,0);
        add(0,1,1,32'h30,5,1,0,32'h100,0,0, 0,32'h100,0,1,1,1);
        add(0,1,1,32'h30,5,1,0,32'h100,0,0, 1,32'h30,5,0,0,0);
        add(0,0,0,32'h30,0,1,0,32'h100,0,0, 0,32'h30,0,0,0,0);
        add(0,0,0,32'h30,0,1,0,32'h100,0,0, 0,32'h100,0,0,1,1);
        add(0,0,0,32'h30,0,0,0,0,0,0, 0,32'h30,0,0,0,0);
        // reset on beat 2 of an 8-beat write burst
        add(0,0,0,32'h30,0,1,1,32'h200,7,32'hAA, 0,32'h30,0,0,0,0);
        add(0,0,0,32'h30,0,1,1,32'h200,7,32'hAA, 1,32'h200,32'hAA,0,1,0);
        add(0,0,0,32'h30,0,1,1,32'h200,7,32'hAA, 1,32'h204,32'hAA,0,1,0);
        add(1,0,0,32'h30,0,1,1,32'h200,7,32'hAA, 0,0,0,0,0,0);
        add(0,1,1,32'h44,7,0,0,0,0,0, 1,32'h44,7,0,0,0);
        add(0,0,0,32'h44,0,0,0,0,0,0, 0,32'h44,0,0,0,0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; a_req = vecs[i].ar; a_we = vecs[i].aw;
            a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
            b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba;
            b_len = vecs[i].bl; b_wdata = vecs[i].bd;
            mem_rdata = $urandom;
            @(negedge clk);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_b_done", i), 32'(b_done), 32'(vecs[i].e_done));
            if (!vecs[i].rst) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
                chk($sformatf("v%0d_a_stall", i), 32'(a_stall), 32'(vecs[i].e_stall));
                chk($sformatf("v%0d_b_ack", i), 32'(b_ack), 32'(vecs[i].e_ack));
            end
            model_update();
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            a_req    = ($urandom_range(0, 99) < 55);
            a_we     = $urandom_range(0, 1);
            a_memlen = 3'($urandom_range(0, 7));
            a_addr   = $urandom;
            a_wdata  = $urandom;
            b_req    = ($urandom_range(0, 99) < 60);
            b_we     = $urandom_range(0, 1);
            b_memlen = 3'($urandom_range(0, 7));
            b_addr   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 : $urandom;
            b_len    = 4'($urandom_range(0, 15));
            b_wdata  = $urandom;
            mem_rdata = $urandom;
            @(negedge clk);
            model_check();
            model_update();
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
